core_lsu: RTL

Load/store unit for the Adelie core. It takes the effective address produced by `core_alu` and the one-hot load/store decode, then runs a single data-memory transaction over a req/ack handshake. It returns sign- or zero-extended load data, or writes byte-lane-aligned store data. It sits directly downstream of `core_alu` and upstream of register writeback.

---
 rtl/core_lsu_pkg.sv | 82 ++++++++
 rtl/core_lsu_if.sv | 23 ++
 rtl/core_lsu_align.sv | 54 +++++
 rtl/core_lsu.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared types for the Adelie load/store unit: FSM states, internal op encoding,
// byte-enable constants and small decode helpers.
package core_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned NOPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding matches the bit position of each op in the one-hot select vector.
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [NBYTES-1:0] BE_B0  = 4'b0001;
  localparam logic [NBYTES-1:0] BE_B1  = 4'b0010;
  localparam logic [NBYTES-1:0] BE_B2  = 4'b0100;
  localparam logic [NBYTES-1:0] BE_B3  = 4'b1000;
  localparam logic [NBYTES-1:0] BE_HLO = 4'b0011;
  localparam logic [NBYTES-1:0] BE_HHI = 4'b1100;
  localparam logic [NBYTES-1:0] BE_W   = 4'b1111;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [NBYTES-1:0] be;
    logic [XLEN-1:0]   wdata;
  } mem_cmd_t;

  function automatic size_e op_size(input op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      default:              return SZ_W;
    endcase
  endfunction

  function automatic logic op_unsigned(input op_e op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_misaligned(input op_e op, input logic [1:0] lo);
    case (op_size(op))
      SZ_H:    return lo[0];
      SZ_W:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Only meaningful for a one-hot select; validity is checked separately.
  function automatic op_e op_decode(input logic [NOPS-1:0] sel);
    op_e op;
    op = OP_LB;
    for (int i = 0; i < int'(NOPS); i++) begin
      if (sel[i]) op = op_e'(3'(i));
    end
    return op;
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Data-memory req/ack bus between core_lsu (master) and the data memory (slave).
interface core_lsu_if;
  import core_lsu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [NBYTES-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/core_lsu_align.sv
// Byte-lane logic shared by the store and load paths: byte enables,
// store-data replication and load extraction with sign/zero extension.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  op_e               i_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_st_data,
  input  logic [XLEN-1:0]   i_ld_word,
  output logic [NBYTES-1:0] o_be_c,
  output logic [XLEN-1:0]   o_st_rep_c,
  output logic [XLEN-1:0]   o_ld_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte      = i_ld_word[7:0];
    w_half      = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    w_sext      = !op_unsigned(i_op);
    o_be_c      = BE_W;
    o_st_rep_c  = i_st_data;
    o_ld_data_c = i_ld_word;

    case (i_addr_lo)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase

    case (op_size(i_op))
      SZ_B: begin
        case (i_addr_lo)
          2'd0:    o_be_c = BE_B0;
          2'd1:    o_be_c = BE_B1;
          2'd2:    o_be_c = BE_B2;
          default: o_be_c = BE_B3;
        endcase
        o_st_rep_c  = {4{i_st_data[7:0]}};
        o_ld_data_c = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_be_c      = i_addr_lo[1] ? BE_HHI : BE_HLO;
        o_st_rep_c  = {2{i_st_data[15:0]}};
        o_ld_data_c = {{16{w_sext & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: runs one data-memory transaction per accepted start and
// returns extended load data; all outputs are registered.
module core_lsu
  import core_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            i_lb,
  input  logic            i_lh,
  input  logic            i_lw,
  input  logic            i_lbu,
  input  logic            i_lhu,
  input  logic            i_sb,
  input  logic            i_sh,
  input  logic            i_sw,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  core_lsu_if.master      mem
);

  state_e            r_state, w_state_nxt;
  op_e               r_op, w_op_nxt;
  logic [1:0]        r_addr_lo, w_addr_lo_nxt;
  mem_cmd_t          r_cmd, w_cmd_nxt;
  logic              r_req, w_req_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_mis, w_mis_nxt;
  logic [XLEN-1:0]   r_rdata, w_rdata_nxt;

  logic [NOPS-1:0]   w_sel;
  logic              w_sel_ok;
  op_e               w_in_op;
  logic              w_in_mis;
  op_e               w_align_op;
  logic [1:0]        w_align_lo;
  logic [NBYTES-1:0] w_be;
  logic [XLEN-1:0]   w_st_rep;
  logic [XLEN-1:0]   w_ld_data;

  assign w_sel    = {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb};
  assign w_sel_ok = $onehot(w_sel);
  assign w_in_op  = op_decode(w_sel);
  assign w_in_mis = op_misaligned(w_in_op, addr[1:0]);

  // In IDLE the lane logic serves the incoming store; afterwards the held load.
  assign w_align_op = (r_state == ST_IDLE) ? w_in_op : r_op;
  assign w_align_lo = (r_state == ST_IDLE) ? addr[1:0] : r_addr_lo;

  core_lsu_align u_align (
    .i_op        (w_align_op),
    .i_addr_lo   (w_align_lo),
    .i_st_data   (wdata),
    .i_ld_word   (mem.mem_rdata),
    .o_be_c      (w_be),
    .o_st_rep_c  (w_st_rep),
    .o_ld_data_c (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LB;
      r_addr_lo <= 2'b00;
      r_cmd     <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mis     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_addr_lo <= w_addr_lo_nxt;
      r_cmd     <= w_cmd_nxt;
      r_req     <= w_req_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_mis     <= w_mis_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_addr_lo_nxt = r_addr_lo;
    w_cmd_nxt     = r_cmd;
    w_req_nxt     = r_req;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_mis_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;

    case (r_state)
      ST_IDLE: begin
        if (start && w_sel_ok) begin
          w_busy_nxt = 1'b1;
          if (w_in_mis) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_mis_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt     = ST_REQ;
            w_op_nxt        = w_in_op;
            w_addr_lo_nxt   = addr[1:0];
            w_req_nxt       = 1'b1;
            w_cmd_nxt.we    = op_store(w_in_op);
            w_cmd_nxt.addr  = {addr[XLEN-1:2], 2'b00};
            w_cmd_nxt.be    = w_be;
            w_cmd_nxt.wdata = w_st_rep;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          w_state_nxt = ST_DONE;
          w_req_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_rdata_nxt = op_store(r_op) ? '0 : w_ld_data;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign rdata         = r_rdata;
  assign misaligned    = r_mis;
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_cmd.we;
  assign mem.mem_addr  = r_cmd.addr;
  assign mem.mem_be    = r_cmd.be;
  assign mem.mem_wdata = r_cmd.wdata;

endmodule
